// File: rtl/sap_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// sap_bus_arbiter_if
// Purpose : bundles the bus-request and bus-enable signals that pass between
//           the control unit and the data-bus arbiter.
// Signals : req   [3:0]  bus requests, bit 0 = driver 1 ... bit 3 = driver 4
//           g     [3:0]  tri-state enables to buffer sections 1-4 (one-hot/zero)
//           gnt   [3:0]  grant copy of g for control-unit fan-out
//           owner [1:0]  encoded owner (0 = driver 1 ... 3 = driver 4), 0 idle
//           busy         high while any g bit is high
// Modports: master - arbiter side (drives enables, reads requests)
//           slave  - control-unit side (drives requests, reads enables)
// ---------------------------------------------------------------------------
interface sap_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] g;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;

  modport master (input req, output g, output gnt, output owner, output busy);
  modport slave  (output req, input g, input gnt, input owner, input busy);
endinterface

// File: rtl/sap_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sap_bus_arbiter
// Purpose : round-robin owner selection for the shared tri-state data bus.
//           Produces one-hot-or-zero enables for the quad bus buffer, inserts
//           one idle turnaround cycle between owners and preempts an owner
//           that has held the bus for MAXHOLD cycles while others wait.
// Params  : MAXHOLD  cycles an owner may keep the bus under contention (1-255)
// Ports   : clk_i    system clock, rising edge
//           clr_n_i  asynchronous active-low clear
//           bus      sap_bus_arbiter_if.master (req in; g/gnt/owner/busy out)
// ---------------------------------------------------------------------------
module sap_bus_arbiter #(
  parameter int unsigned MAXHOLD = 8
) (
  input  logic              clk_i,
  input  logic              clr_n_i,
  sap_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] g_q, g_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;

  logic       winFound;
  logic [1:0] winIdx;
  logic [1:0] cand;
  logic       othersReq;
  logic       holdExpired;

  // Scan upward from the pointer; the 2-bit add provides the 4->1 wrap.
  always_comb begin
    winFound = 1'b0;
    winIdx   = ptr_q;
    cand     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!winFound && bus.req[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  assign othersReq = |(bus.req & ~g_q);

  // hold_q counts edges already kept, so the edge that would complete the
  // MAXHOLD-th owned cycle is the one where hold_q + 1 reaches MAXHOLD.
  assign holdExpired = ({1'b0, hold_q} + 9'd1) >= 9'(MAXHOLD);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, TURN: begin
        if (winFound) begin
          state_d = GRANT;
          g_d     = 4'b0001 << winIdx;
          owner_d = winIdx;
          hold_d  = 8'd0;
          ptr_d   = winIdx + 2'd1;
        end else begin
          state_d = IDLE;
          g_d     = 4'b0000;
          owner_d = 2'd0;
        end
      end
      GRANT: begin
        // A release wins over a simultaneous preemption; both go to TURN.
        if (!bus.req[owner_q]) begin
          state_d = TURN;
          g_d     = 4'b0000;
          owner_d = 2'd0;
        end else begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
          if (holdExpired && othersReq) begin
            state_d = TURN;
            g_d     = 4'b0000;
            owner_d = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = 4'b0000;
        owner_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q <= IDLE;
      g_q     <= 4'b0000;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.g     = g_q;
  assign bus.gnt   = g_q;
  assign bus.owner = owner_q;
  assign bus.busy  = |g_q;

endmodule
